// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the three-port SDRAM arbiter.
// Holds the sequencer state encoding, grant codes, bus widths and a helper
// that aligns VGA burst addresses to a 32-word boundary.
package mem_arb_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_DONE
  } state_e;

  // Grant codes as seen on the grant output
  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_INS  = 2'd1;
  localparam logic [1:0] GNT_DAT  = 2'd2;
  localparam logic [1:0] GNT_VGA  = 2'd3;

  // Which CPU port was served last (round-robin memory)
  localparam logic LAST_DAT = 1'b0;
  localparam logic LAST_INS = 1'b1;

  // VGA bursts always start on a 32-word boundary
  function automatic logic [ADDR_W-1:0] burst_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:5], 5'b00000};
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection for the SDRAM arbiter.
// Ports:
//   vga_req_i, dat_req_i, ins_req_i : pending requests
//   starve_cnt_i                    : consecutive VGA grants with CPU waiting
//   last_cpu_i                      : CPU port served last (LAST_DAT/LAST_INS)
//   grant_o                         : winning grant code, GNT_NONE if idle
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       vga_req_i,
  input  logic       dat_req_i,
  input  logic       ins_req_i,
  input  logic [2:0] starve_cnt_i,
  input  logic       last_cpu_i,
  output logic [1:0] grant_o
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [1:0] cpuPick;
  logic       cpuPend;
  logic       starved;

  assign cpuPend = dat_req_i | ins_req_i;
  assign starved = (starve_cnt_i == LIMIT);

  // On a data/instruction tie, serve the port that did not go last
  always_comb begin
    cpuPick = GNT_NONE;
    if (dat_req_i && ins_req_i) begin
      cpuPick = (last_cpu_i == LAST_INS) ? GNT_DAT : GNT_INS;
    end else if (dat_req_i) begin
      cpuPick = GNT_DAT;
    end else if (ins_req_i) begin
      cpuPick = GNT_INS;
    end
  end

  // VGA has priority unless the CPU has been starved long enough
  always_comb begin
    grant_o = cpuPick;
    if (vga_req_i && !(starved && cpuPend)) begin
      grant_o = GNT_VGA;
    end
  end

endmodule

// File: rtl/sdram_arb.sv
// Three-port arbiter and sequencer in front of sdram_ctl.
// Shares one controller port between VGA bursts, CPU data and CPU fetch,
// one transaction in flight at a time.
// Ports:
//   clk, rst                          : clock, async active-high reset
//   vga_req/vga_addr/vga_done         : VGA burst port
//   dat_req/we/addr/wdata/rdata/done  : CPU data port
//   ins_req/addr/rdata/done           : CPU instruction port
//   ctl_ready/data_ready/data_out     : status from sdram_ctl
//   ctl_start/write_en/burst_en/addr/data_in : command to sdram_ctl
//   grant                             : current owner code
//   timeout_err                       : sticky handshake timeout flag
module sdram_arb
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_req,
  input  logic [24:0] vga_addr,
  output logic        vga_done,
  input  logic        dat_req,
  input  logic        dat_we,
  input  logic [24:0] dat_addr,
  input  logic [15:0] dat_wdata,
  output logic [15:0] dat_rdata,
  output logic        dat_done,
  input  logic        ins_req,
  input  logic [24:0] ins_addr,
  output logic [15:0] ins_rdata,
  output logic        ins_done,
  input  logic        ctl_ready,
  input  logic        ctl_data_ready,
  input  logic [15:0] ctl_data_out,
  output logic        ctl_start,
  output logic        ctl_write_en,
  output logic        ctl_burst_en,
  output logic [24:0] ctl_addr,
  output logic [15:0] ctl_data_in,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam logic [2:0] LIMIT     = 3'(STARVE_LIMIT);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [2:0]  starveCnt_q, starveCnt_d;
  logic        lastCpu_q, lastCpu_d;
  logic [7:0]  waitCnt_q, waitCnt_d;
  logic [24:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic        burst_q, burst_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdBuf_q, rdBuf_d;
  logic        rdValid_q, rdValid_d;
  logic [15:0] datRdata_q, datRdata_d;
  logic [15:0] insRdata_q, insRdata_d;
  logic        timeoutErr_q, timeoutErr_d;

  logic [1:0]  winner;
  logic [7:0]  waitNext;
  logic        timedOut;
  logic        singleRead;
  logic [15:0] readWord;

  arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .vga_req_i   (vga_req),
    .dat_req_i   (dat_req),
    .ins_req_i   (ins_req),
    .starve_cnt_i(starveCnt_q),
    .last_cpu_i  (lastCpu_q),
    .grant_o     (winner)
  );

  // waitCnt counts cycles since the ISSUE cycle; hitting TIMEOUT aborts
  assign waitNext   = waitCnt_q + 8'd1;
  assign timedOut   = (waitNext == TIMEOUT_C);
  assign singleRead = !we_q && !burst_q;
  // A data_ready pulse coinciding with the final ready edge is still taken
  assign readWord   = ctl_data_ready ? ctl_data_out : rdBuf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= GNT_NONE;
      starveCnt_q  <= 3'd0;
      lastCpu_q    <= LAST_INS;
      waitCnt_q    <= 8'd0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      burst_q      <= 1'b0;
      wdata_q      <= '0;
      rdBuf_q      <= '0;
      rdValid_q    <= 1'b0;
      datRdata_q   <= '0;
      insRdata_q   <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      starveCnt_q  <= starveCnt_d;
      lastCpu_q    <= lastCpu_d;
      waitCnt_q    <= waitCnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      burst_q      <= burst_d;
      wdata_q      <= wdata_d;
      rdBuf_q      <= rdBuf_d;
      rdValid_q    <= rdValid_d;
      datRdata_q   <= datRdata_d;
      insRdata_q   <= insRdata_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    starveCnt_d  = starveCnt_q;
    lastCpu_d    = lastCpu_q;
    waitCnt_d    = waitCnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    burst_d      = burst_q;
    wdata_d      = wdata_q;
    rdBuf_d      = rdBuf_q;
    rdValid_d    = rdValid_q;
    datRdata_d   = datRdata_q;
    insRdata_d   = insRdata_q;
    timeoutErr_d = timeoutErr_q;

    // Read data is buffered during the handshake and only committed on a
    // clean completion, so an aborted read leaves the holding register alone
    if ((state_q == ST_WAIT_ACK || state_q == ST_WAIT_DONE) &&
        singleRead && ctl_data_ready) begin
      rdBuf_d   = ctl_data_out;
      rdValid_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (ctl_ready && winner != GNT_NONE) begin
          grant_d = winner;
          state_d = ST_ISSUE;
          unique case (winner)
            GNT_VGA: begin
              addr_d  = burst_align(vga_addr);
              we_d    = 1'b0;
              burst_d = 1'b1;
              wdata_d = '0;
              if ((dat_req || ins_req) && starveCnt_q != LIMIT) begin
                starveCnt_d = starveCnt_q + 3'd1;
              end
            end
            GNT_DAT: begin
              addr_d      = dat_addr;
              we_d        = dat_we;
              burst_d     = 1'b0;
              wdata_d     = dat_wdata;
              starveCnt_d = 3'd0;
              lastCpu_d   = LAST_DAT;
            end
            GNT_INS: begin
              addr_d      = ins_addr;
              we_d        = 1'b0;
              burst_d     = 1'b0;
              wdata_d     = '0;
              starveCnt_d = 3'd0;
              lastCpu_d   = LAST_INS;
            end
            default: ;
          endcase
        end
      end
      ST_ISSUE: begin
        state_d   = ST_WAIT_ACK;
        waitCnt_d = 8'd1;
        rdValid_d = 1'b0;
      end
      ST_WAIT_ACK: begin
        waitCnt_d = waitNext;
        if (!ctl_ready) begin
          state_d = ST_WAIT_DONE;
        end else if (timedOut) begin
          timeoutErr_d = 1'b1;
          state_d      = ST_DONE;
        end
      end
      ST_WAIT_DONE: begin
        waitCnt_d = waitNext;
        if (ctl_ready) begin
          state_d = ST_DONE;
          if (singleRead && (rdValid_q || ctl_data_ready)) begin
            if (grant_q == GNT_DAT) datRdata_d = readWord;
            if (grant_q == GNT_INS) insRdata_d = readWord;
          end
        end else if (timedOut) begin
          timeoutErr_d = 1'b1;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ctl_start    = (state_q == ST_ISSUE);
  assign ctl_write_en = we_q;
  assign ctl_burst_en = burst_q;
  assign ctl_addr     = addr_q;
  assign ctl_data_in  = wdata_q;
  assign grant        = grant_q;
  assign timeout_err  = timeoutErr_q;
  assign dat_rdata    = datRdata_q;
  assign ins_rdata    = insRdata_q;
  assign vga_done     = (state_q == ST_DONE) && (grant_q == GNT_VGA);
  assign dat_done     = (state_q == ST_DONE) && (grant_q == GNT_DAT);
  assign ins_done     = (state_q == ST_DONE) && (grant_q == GNT_INS);

endmodule

// File: tb/tb_sdram_arb.sv
// Scoreboard bench for sdram_arb with a small sdram_ctl behavioural model.
// Stimulus pushes expected commands and completions; a negedge monitor pops
// and compares whenever ctl_start or a done strobe appears.
module tb_sdram_arb;

  logic        clk;
  logic        rst;
  logic        vga_req;
  logic [24:0] vga_addr;
  logic        vga_done;
  logic        dat_req;
  logic        dat_we;
  logic [24:0] dat_addr;
  logic [15:0] dat_wdata;
  logic [15:0] dat_rdata;
  logic        dat_done;
  logic        ins_req;
  logic [24:0] ins_addr;
  logic [15:0] ins_rdata;
  logic        ins_done;
  logic        ctl_ready;
  logic        ctl_data_ready;
  logic [15:0] ctl_data_out;
  logic        ctl_start;
  logic        ctl_write_en;
  logic        ctl_burst_en;
  logic [24:0] ctl_addr;
  logic [15:0] ctl_data_in;
  logic [1:0]  grant;
  logic        timeout_err;

  sdram_arb #(
    .STARVE_LIMIT(4),
    .TIMEOUT     (255)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .vga_req       (vga_req),
    .vga_addr      (vga_addr),
    .vga_done      (vga_done),
    .dat_req       (dat_req),
    .dat_we        (dat_we),
    .dat_addr      (dat_addr),
    .dat_wdata     (dat_wdata),
    .dat_rdata     (dat_rdata),
    .dat_done      (dat_done),
    .ins_req       (ins_req),
    .ins_addr      (ins_addr),
    .ins_rdata     (ins_rdata),
    .ins_done      (ins_done),
    .ctl_ready     (ctl_ready),
    .ctl_data_ready(ctl_data_ready),
    .ctl_data_out  (ctl_data_out),
    .ctl_start     (ctl_start),
    .ctl_write_en  (ctl_write_en),
    .ctl_burst_en  (ctl_burst_en),
    .ctl_addr      (ctl_addr),
    .ctl_data_in   (ctl_data_in),
    .grant         (grant),
    .timeout_err   (timeout_err)
  );

  typedef struct {
    logic [1:0]  code;
    logic [24:0] addr;
    logic        we;
    logic        burst;
    logic [15:0] wdata;
  } startExp_t;

  typedef struct {
    logic [1:0]  code;
    logic [15:0] datR;
    logic [15:0] insR;
    logic        err;
  } doneExp_t;

  startExp_t   startQ[$];
  doneExp_t    doneQ[$];
  logic [15:0] mem [logic [24:0]];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lastStart = -1;
  logic hangMode = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: event did not happen as expected", name);
  endtask

  task automatic pushStart(input logic [1:0] code, input logic [24:0] addr,
                           input logic we, input logic burst, input logic [15:0] wdata);
    startExp_t s;
    s.code = code; s.addr = addr; s.we = we; s.burst = burst; s.wdata = wdata;
    startQ.push_back(s);
  endtask

  task automatic pushDone(input logic [1:0] code, input logic [15:0] datR,
                          input logic [15:0] insR, input logic err);
    doneExp_t d;
    d.code = code; d.datR = datR; d.insR = insR; d.err = err;
    doneQ.push_back(d);
  endtask

  task automatic applyStimulus(input logic v, input logic d, input logic i);
    vga_req = v;
    dat_req = d;
    ins_req = i;
  endtask

  // Returns inside the cycle of the last expected done strobe
  task automatic waitDrain(input int maxCycles, input string name);
    int n = 0;
    while (doneQ.size() != 0 && n < maxCycles) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (doneQ.size() != 0) begin
      reportFail(name);
      doneQ.delete();
      startQ.delete();
    end
  endtask

  // sdram_ctl model: ready drops one cycle after start, read data pulses
  // two cycles later, ready returns two cycles after that.  In hang mode
  // ready never drops but the read data pulse still appears.
  initial begin
    logic [24:0] mAddr;
    logic        mWe;
    logic        mBurst;
    logic [15:0] mData;
    ctl_ready      = 1'b1;
    ctl_data_ready = 1'b0;
    ctl_data_out   = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      if (ctl_start) begin
        mAddr  = ctl_addr;
        mWe    = ctl_write_en;
        mBurst = ctl_burst_en;
        mData  = ctl_data_in;
        @(posedge clk);
        #1;
        if (!hangMode) ctl_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (mWe) begin
          mem[mAddr] = mData;
        end else if (!mBurst) begin
          ctl_data_ready = 1'b1;
          ctl_data_out   = mem.exists(mAddr) ? mem[mAddr] : 16'h0;
        end
        @(posedge clk);
        #1;
        ctl_data_ready = 1'b0;
        @(posedge clk);
        #1;
        ctl_ready = 1'b1;
      end
    end
  end

  startExp_t  sExp;
  doneExp_t   dExp;
  logic [1:0] doneCode;
  logic [2:0] doneVec;

  always @(negedge clk) begin
    if (!rst) begin
      if (ctl_start) begin
        if (startQ.size() == 0) begin
          reportFail("unexpectedStart");
        end else begin
          sExp = startQ.pop_front();
          checkOutput("startGrant", 32'(grant), 32'(sExp.code));
          checkOutput("startAddr", 32'(ctl_addr), 32'(sExp.addr));
          checkOutput("startWe", 32'(ctl_write_en), 32'(sExp.we));
          checkOutput("startBurst", 32'(ctl_burst_en), 32'(sExp.burst));
          if (sExp.we) checkOutput("startWdata", 32'(ctl_data_in), 32'(sExp.wdata));
        end
        if (lastStart >= 0) checkOutput("startSpacing", 32'((cyc - lastStart) >= 4), 32'd1);
        lastStart = cyc;
      end
      doneVec = {vga_done, dat_done, ins_done};
      if (doneVec != 3'b000) begin
        case (doneVec)
          3'b001:  doneCode = 2'd1;
          3'b010:  doneCode = 2'd2;
          3'b100:  doneCode = 2'd3;
          default: doneCode = 2'd0;
        endcase
        if (doneQ.size() == 0) begin
          reportFail("unexpectedDone");
        end else begin
          dExp = doneQ.pop_front();
          checkOutput("doneCode", 32'(doneCode), 32'(dExp.code));
          checkOutput("datRdata", 32'(dat_rdata), 32'(dExp.datR));
          checkOutput("insRdata", 32'(ins_rdata), 32'(dExp.insR));
          checkOutput("timeoutErr", 32'(timeout_err), 32'(dExp.err));
        end
      end
    end
  end

  initial begin
    int n;
    int startCyc;
    logic [15:0] expDat;

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    vga_addr  = '0;
    dat_we    = 1'b0;
    dat_addr  = '0;
    dat_wdata = '0;
    ins_addr  = '0;
    mem[25'h3]  = 16'h4809;
    mem[25'h4]  = 16'h7E01;
    mem[25'h10] = 16'h00C3;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstGrant", 32'(grant), 32'd0);
    checkOutput("rstStart", 32'(ctl_start), 32'd0);
    checkOutput("rstDatRdata", 32'(dat_rdata), 32'd0);
    checkOutput("rstInsRdata", 32'(ins_rdata), 32'd0);
    checkOutput("rstTimeout", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Data write to address 0
    $display("[TB] data write");
    dat_we    = 1'b1;
    dat_addr  = 25'h0;
    dat_wdata = 16'hABAB;
    pushStart(2'd2, 25'h0, 1'b1, 1'b0, 16'hABAB);
    pushDone(2'd2, 16'h0, 16'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reqToStart", 32'(ctl_start), 32'd1);
    waitDrain(50, "writeDone");
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("grantCleared", 32'(grant), 32'd0);
    checkOutput("memWrite", 32'(mem.exists(25'h0) ? mem[25'h0] : 16'h0), 32'h0000ABAB);

    // Lone instruction read at address 3
    $display("[TB] instruction read");
    ins_addr = 25'h3;
    pushStart(2'd1, 25'h3, 1'b0, 1'b0, 16'h0);
    pushDone(2'd1, 16'h0, 16'h4809, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitDrain(50, "insDone");
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // VGA burst with unaligned base address
    $display("[TB] vga burst");
    vga_addr = 25'h0401C27;
    pushStart(2'd3, 25'h0401C20, 1'b0, 1'b1, 16'h0);
    pushDone(2'd3, 16'h0, 16'h4809, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDrain(50, "vgaDone");
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // All three held: VGA x4, data, VGA x4, instruction
    $display("[TB] three-way contention");
    dat_we   = 1'b0;
    dat_addr = 25'h0;
    expDat   = 16'h0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        expDat = 16'hABAB;
        pushStart(2'd2, 25'h0, 1'b0, 1'b0, 16'h0);
        pushDone(2'd2, expDat, 16'h4809, 1'b0);
      end else if (k == 9) begin
        pushStart(2'd1, 25'h3, 1'b0, 1'b0, 16'h0);
        pushDone(2'd1, expDat, 16'h4809, 1'b0);
      end else begin
        pushStart(2'd3, 25'h0401C20, 1'b0, 1'b1, 16'h0);
        pushDone(2'd3, expDat, 16'h4809, 1'b0);
      end
    end
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitDrain(400, "contentionDone");
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Data and instruction only: strict alternation starting with data
    $display("[TB] cpu round robin");
    dat_addr = 25'h10;
    ins_addr = 25'h4;
    pushStart(2'd2, 25'h10, 1'b0, 1'b0, 16'h0);
    pushDone(2'd2, 16'h00C3, 16'h4809, 1'b0);
    pushStart(2'd1, 25'h4, 1'b0, 1'b0, 16'h0);
    pushDone(2'd1, 16'h00C3, 16'h7E01, 1'b0);
    pushStart(2'd2, 25'h10, 1'b0, 1'b0, 16'h0);
    pushDone(2'd2, 16'h00C3, 16'h7E01, 1'b0);
    pushStart(2'd1, 25'h4, 1'b0, 1'b0, 16'h0);
    pushDone(2'd1, 16'h00C3, 16'h7E01, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitDrain(200, "rrDone");
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Controller never drops ready: abort after 255 cycles, rdata kept
    $display("[TB] handshake timeout");
    hangMode = 1'b1;
    ins_addr = 25'h3;
    pushStart(2'd1, 25'h3, 1'b0, 1'b0, 16'h0);
    pushDone(2'd1, 16'h00C3, 16'h7E01, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ctl_start && n < 20);
    startCyc = cyc;
    if (!ctl_start) reportFail("timeoutStart");
    n = 0;
    while (!timeout_err && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("timeoutLatency", 32'(cyc - startCyc), 32'd255);
    waitDrain(10, "timeoutDone");
    applyStimulus(1'b0, 1'b0, 1'b0);
    hangMode = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Reset in WAIT_DONE, then a normal request
    $display("[TB] reset mid-transaction");
    pushStart(2'd1, 25'h3, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    n = 0;
    while (ctl_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (ctl_ready) reportFail("readyDrop");
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midRstGrant", 32'(grant), 32'd0);
    checkOutput("midRstStart", 32'(ctl_start), 32'd0);
    checkOutput("midRstInsDone", 32'(ins_done), 32'd0);
    checkOutput("midRstInsRdata", 32'(ins_rdata), 32'd0);
    checkOutput("midRstDatRdata", 32'(dat_rdata), 32'd0);
    checkOutput("midRstTimeout", 32'(timeout_err), 32'd0);
    checkOutput("midRstAddr", 32'(ctl_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    startQ.delete();
    doneQ.delete();
    n = 0;
    while (!ctl_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    pushStart(2'd1, 25'h3, 1'b0, 1'b0, 16'h0);
    pushDone(2'd1, 16'h0, 16'h4809, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitDrain(50, "postRstDone");
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    if (startQ.size() != 0) reportFail("startQueueLeftover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arb.md
# sdram_arb

Three-port arbiter and sequencer in front of `sdram_ctl`. It shares the single SDRAM controller port between three requesters:
- the VGA line-burst fetcher;
- the CPU data port (read/write);
- the CPU instruction-fetch port.

It sits between `mem_map`'s address decode and `sdram_ctl`. One transaction is in flight at a time. Per-port completion strobes and read-data holding registers are returned to each requester.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: consecutive VGA grants allowed while a CPU request is pending before one CPU grant is forced.
- `TIMEOUT`, 255: maximum cycles in WAIT states before abort; 8-bit counter.

Ports:
- `clk`  in  1  system clock; one clock domain only.
- `rst`  in  1  reset, asynchronous, active-high.
- `vga_req`  in  1  VGA burst request, level, held until `vga_done`.
- `vga_addr`  in  25  burst base address; low 5 bits ignored and forced to 0.
- `vga_done`  out  1  one-cycle pulse; `sdram_ctl` burst buffer is valid this cycle.
- `dat_req`  in  1  CPU data request, level.
- `dat_we`  in  1  1 = write, 0 = read.
- `dat_addr`  in  25  data word address.
- `dat_wdata`  in  16  write data.
- `dat_rdata`  out  16  last read data; held until the next data read completes.
- `dat_done`  out  1  one-cycle completion pulse.
- `ins_req`  in  1  instruction fetch request, level; always a read.
- `ins_addr`  in  25  fetch address.
- `ins_rdata`  out  16  last fetched word; held.
- `ins_done`  out  1  one-cycle completion pulse.
- `ctl_ready`  in  1  `sdram_ctl` `mem_ready`.
- `ctl_data_ready`  in  1  `sdram_ctl` `data_ready`.
- `ctl_data_out`  in  16  `sdram_ctl` `data_out`.
- `ctl_start`  out  1  one-cycle start strobe; drives `refresh_data`.
- `ctl_write_en`, `ctl_burst_en`  out  1 each  transaction type.
- `ctl_addr`  out  25  transaction address.
- `ctl_data_in`  out  16  write data.
- `grant`  out  2  current owner: 0 none, 1 instruction, 2 data, 3 VGA.
- `timeout_err`  out  1  sticky; cleared only by `rst`.

## Operation
States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, DONE.

- **IDLE**
  - If `ctl_ready` is high and any request is pending, pick the winner.
  - Latch the winner's address, write enable, write data and type into registers.
  - Set `grant`, then go to ISSUE.
  - Requests are sampled only in IDLE.
- **Winner selection**
  - VGA wins by default.
  - Exception: if `starve_cnt == STARVE_LIMIT` and a CPU request is pending, a CPU port wins.
  - Between data and instruction, selection is round-robin via `last_cpu`; data wins the first tie after reset.
- **ISSUE**: `ctl_start` = 1 for exactly one cycle, then WAIT_ACK.
- **WAIT_ACK**: wait for `ctl_ready` = 0, then go to WAIT_DONE.
- **WAIT_DONE**: wait for `ctl_ready` = 1, then go to DONE.
  - Any `ctl_data_ready` pulse seen in WAIT_ACK or WAIT_DONE during a single read loads the owner's rdata register with `ctl_data_out`.
- **DONE**: the owner's done output = 1 for one cycle; `grant` returns to 0; go to IDLE.
- **Starvation counter `starve_cnt`** (3 bits, saturating at `STARVE_LIMIT`):
  - increments on a VGA grant while any CPU request is pending;
  - clears on any CPU grant.
- **Timeout**: the cycle counter resets on entering WAIT_ACK.
  - If it reaches `TIMEOUT` in either WAIT state, set `timeout_err` and go to DONE.
  - The done pulse is still issued, and rdata is not updated.
- **Request dropped mid-transaction**: the transaction completes normally and done still pulses.
- **Write**: rdata is unchanged.
- **VGA**: no rdata register; the burst data is read by the requester directly from `sdram_ctl` `burst_buf`.

## Timing
- **Reset**: the async `rst` forces state IDLE. All outputs are 0 (`grant` = 0, both rdata = 0, `timeout_err` = 0), `starve_cnt` = 0 and `last_cpu` = instruction. This holds even mid-transaction; the controller re-handshakes from IDLE.
- **Request to `ctl_start`**: a request sampled in IDLE at edge N gives `ctl_start` high in cycle N+1.
- **Stable outputs**: `ctl_addr`, `ctl_write_en`, `ctl_burst_en` and `ctl_data_in` are registered. They are stable from ISSUE through DONE.
- **Completion latency**: done asserts one cycle after `ctl_ready` is sampled high in WAIT_DONE.
- **Best-case turnaround**: 2 cycles of arbiter overhead plus controller latency.
- **Back-to-back**: minimum one IDLE cycle between transactions, so `ctl_start` pulses are at least 4 cycles apart.

## Structure
- **Package `mem_arb_pkg`**:
  - state enum;
  - grant constants `GNT_NONE`, `GNT_INS`, `GNT_DAT`, `GNT_VGA`;
  - address width 25 and data width 16 constants.
- **Sub-module `arb_pick`**: combinational winner selection from requests, `starve_cnt`, `STARVE_LIMIT` and `last_cpu`. It is unit-testable separately.
- **Top module**: the FSM, counters and data registers.

## Test plan
- **Lone instruction read**: `ins_req` at address 0x000003, controller model returns 0x4809.
  - `ctl_start` pulses with `ctl_addr` = 3 and `ctl_write_en` = 0.
  - `ins_done` pulses once and `ins_rdata` = 0x4809.
- **Data write**: `dat_we` = 1, address 0, data 0xABAB.
  - `ctl_write_en` = 1 and `ctl_data_in` = 0xABAB.
  - `dat_done` pulses; `dat_rdata` stays at its prior value; SDRAM model address 0 = 0xABAB.
- **All three requests held continuously**:
  - grant order is VGA×4, data, VGA×4, instruction, …;
  - `starve_cnt` never exceeds 4.
- **Data and instruction requests only, continuous**: grants alternate data, instruction, data, …
- **VGA request at `vga_addr` 0x0401C27**:
  - `ctl_addr` = 0x0401C20 and `ctl_burst_en` = 1;
  - `vga_done` pulses.
- **Fault handling**:
  - Controller never drops `ctl_ready`: `timeout_err` = 1 exactly 255 cycles after ISSUE, and done still pulses.
  - `rst` pulsed during WAIT_DONE: all outputs are 0 immediately and the next request is served normally.
